// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one uart_tx among N_REQ byte-stream requesters.
// Optional watchdog on the tx_start -> tx_done_tick interval: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int N_REQ       = 4,
   parameter int ID_W        = 2,
   parameter int TIMEOUT_CYC = 400000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ready,
   output logic               tx_start,
   output logic [7:0]         tx_din,
   input  logic               tx_done_tick,
   output logic [N_REQ-1:0]   grant,
   output logic [ID_W-1:0]    grant_id,
   output logic               busy,
   output logic               timeout_err
);

   if (N_REQ < 1 || N_REQ > 8 || TIMEOUT_CYC < 1 ||
       ID_W != ((N_REQ > 1) ? $clog2(N_REQ) : 1)) begin : g_bad_cfg
      $error("uart_tx_arbiter: inconsistent N_REQ / ID_W / TIMEOUT_CYC");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      NEXT = 2'd2
   } state_t;

   state_t            state, state_next;
   logic [ID_W-1:0]   rr_ptr, rr_ptr_d;
   logic [ID_W-1:0]   sel, cand, load_idx;
   logic              found, load, release_pkt, expire;
   logic              last_q, last_d;
   logic [7:0]        data_arr [N_REQ];

   logic [N_REQ-1:0]  grant_q, grant_d;
   logic [ID_W-1:0]   grant_id_q, grant_id_d;
   logic [N_REQ-1:0]  req_ready_q, req_ready_d;
   logic              tx_start_q, tx_start_d;
   logic [7:0]        tx_din_q, tx_din_d;
   logic              busy_q, busy_d;

   always_comb begin : unpack
      for (int unsigned i = 0; i < N_REQ; i++) begin
         data_arr[i] = req_data[8*i +: 8];
      end
   end

   // First valid requester scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
   always_comb begin : rr_scan
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cand = ID_W'((32'(rr_ptr) + i) % 32'(N_REQ));
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] to_cnt;
   logic             timeout_q;

   assign expire = (to_cnt == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         to_cnt    <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (load) begin
            to_cnt <= '0;
         end else if (state == WAIT) begin
            to_cnt <= to_cnt + CNT_W'(1);
         end
         if (state == WAIT && !tx_done_tick && expire) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign timeout_err = timeout_q;
`else
   assign expire      = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin : state_reg
      if (!rst) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         last_q      <= 1'b0;
         grant_q     <= '0;
         grant_id_q  <= '0;
         req_ready_q <= '0;
         tx_start_q  <= 1'b0;
         tx_din_q    <= '0;
         busy_q      <= 1'b0;
      end else begin
         state       <= state_next;
         rr_ptr      <= rr_ptr_d;
         last_q      <= last_d;
         grant_q     <= grant_d;
         grant_id_q  <= grant_id_d;
         req_ready_q <= req_ready_d;
         tx_start_q  <= tx_start_d;
         tx_din_q    <= tx_din_d;
         busy_q      <= busy_d;
      end
   end

   // A completed frame takes priority over a watchdog expiry in the same cycle.
   always_comb begin : next_state
      state_next  = state;
      load        = 1'b0;
      load_idx    = grant_id_q;
      release_pkt = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               load       = 1'b1;
               load_idx   = sel;
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (tx_done_tick) begin
               if (last_q) begin
                  release_pkt = 1'b1;
                  state_next  = IDLE;
               end else begin
                  state_next  = NEXT;
               end
            end else if (expire) begin
               release_pkt = 1'b1;
               state_next  = IDLE;
            end
         end
         NEXT: begin
            if (req_valid[grant_id_q]) begin
               load       = 1'b1;
               state_next = WAIT;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin : next_outputs
      grant_d     = grant_q;
      grant_id_d  = grant_id_q;
      tx_din_d    = tx_din_q;
      last_d      = last_q;
      rr_ptr_d    = rr_ptr;
      tx_start_d  = load;
      req_ready_d = '0;
      if (load) begin
         grant_d     = N_REQ'(1) << load_idx;
         grant_id_d  = load_idx;
         tx_din_d    = data_arr[load_idx];
         last_d      = req_last[load_idx];
         req_ready_d = N_REQ'(1) << load_idx;
      end
      if (release_pkt) begin
         grant_d    = '0;
         grant_id_d = '0;
         rr_ptr_d   = ID_W'((32'(grant_id_q) + 32'd1) % 32'(N_REQ));
      end
      busy_d = (state_next != IDLE);
   end

   assign req_ready = req_ready_q;
   assign tx_start  = tx_start_q;
   assign tx_din    = tx_din_q;
   assign grant     = grant_q;
   assign grant_id  = grant_id_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-cycle owner/queue model plus directed literal checks.
// The timeout scenario runs only when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;
   localparam int N   = 4;
   localparam int IDW = 2;
   localparam int TO  = 100;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid, req_last, req_ready, grant;
   logic [8*N-1:0] req_data;
   logic           tx_start, tx_done_tick, busy, timeout_err;
   logic [7:0]     tx_din;
   logic [IDW-1:0] grant_id;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.N_REQ(N), .ID_W(IDW), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready), .tx_start(tx_start), .tx_din(tx_din),
      .tx_done_tick(tx_done_tick), .grant(grant), .grant_id(grant_id),
      .busy(busy), .timeout_err(timeout_err)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit bit_at(input logic [N-1:0] x, input int i);
      logic [N-1:0] s;
      s = x >> i;
      return s[0];
   endfunction

   function automatic logic [7:0] byte_at(input logic [8*N-1:0] x, input int i);
      logic [8*N-1:0] s;
      s = x >> (8 * i);
      return s[7:0];
   endfunction

   function automatic logic [N-1:0] onehot(input int i);
      return N'(1) << i;
   endfunction

   // Requester scripts: circular byte queues {last, data}
   logic [8:0] scr [N][256];
   int hd [N], cnt [N], hold [N];
   bit rand_on = 0, spur_en = 0, uart_mute = 0, force_tick = 0;

   // Log of every tx_start seen on the DUT
   int         slog_n = 0;
   logic [7:0] slog_din [1024];
   int         slog_gid [1024];

   // Reference model: owner of the uart, whether a frame is in flight, pointer, plus compare
   initial begin : model_cmp
      int owner, ptr, wcnt, acc;
      bit in_frame, pkt_last, m_err, m_start;
      logic [7:0] m_din;
      logic [N-1:0] m_ready, v, l;
      logic [8*N-1:0] d;
      logic t;
      owner = -1; ptr = 0; wcnt = 0; in_frame = 0; pkt_last = 0; m_err = 0; m_din = '0;
      forever begin
         @(posedge clk);
         v = req_valid; l = req_last; d = req_data; t = tx_done_tick;
         m_start = 0; m_ready = '0; acc = -1;
         if (!rst) begin
            owner = -1; ptr = 0; wcnt = 0; in_frame = 0; pkt_last = 0; m_err = 0; m_din = '0;
         end else if (owner < 0) begin
            for (int k = 0; k < N; k++)
               if (acc < 0 && bit_at(v, (ptr + k) % N)) acc = (ptr + k) % N;
         end else if (in_frame) begin
            if (t) begin
               in_frame = 0;
               if (pkt_last) begin ptr = (owner + 1) % N; owner = -1; end
            end else begin
               wcnt++;
`ifdef UART_ARB_TIMEOUT_EN
               if (wcnt == TO) begin
                  m_err = 1; in_frame = 0; ptr = (owner + 1) % N; owner = -1;
               end
`endif
            end
         end else if (bit_at(v, owner)) begin
            acc = owner;
         end
         if (acc >= 0) begin
            owner = acc; in_frame = 1; wcnt = 0; m_start = 1;
            m_ready = onehot(acc); m_din = byte_at(d, acc); pkt_last = bit_at(l, acc);
         end
         #1;
         chk("tx_start", 32'(tx_start), 32'(m_start));
         chk("req_ready", 32'(req_ready), 32'(m_ready));
         chk("tx_din", 32'(tx_din), 32'(m_din));
         chk("grant", 32'(grant), (owner >= 0) ? 32'(onehot(owner)) : 32'd0);
         chk("grant_id", 32'(grant_id), (owner >= 0) ? 32'(owner) : 32'd0);
         chk("busy", 32'(busy), 32'(owner >= 0));
         chk("timeout_err", 32'(timeout_err), 32'(m_err));
         if (tx_start && slog_n < 1024) begin
            slog_din[slog_n] = tx_din;
            slog_gid[slog_n] = int'(grant_id);
            slog_n++;
         end
      end
   end

   // uart_tx stand-in: frame completes 1..6 cycles after tx_start; optional spurious ticks
   initial begin : uart
      int frame_left;
      frame_left = 0;
      tx_done_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (tx_start && !uart_mute) frame_left = int'($urandom_range(1, 6));
         #2;
         if (frame_left > 0) begin
            frame_left--;
            tx_done_tick = (frame_left == 0);
         end else begin
            tx_done_tick = force_tick | (spur_en && $urandom_range(0, 7) == 0);
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1);
   end

   task automatic push(input int i, input logic [7:0] b, input bit last);
      scr[i][(hd[i] + cnt[i]) % 256] = {last, b};
      cnt[i]++;
   endtask

   task automatic drive();
      logic [8*N-1:0] mask;
      for (int i = 0; i < N; i++) begin
         if (bit_at(req_valid, i) && bit_at(req_ready, i)) begin
            hd[i] = (hd[i] + 1) % 256;
            cnt[i]--;
            req_valid &= ~onehot(i);
            if (rand_on) hold[i] = int'($urandom_range(0, 3));
         end
         if (!bit_at(req_valid, i)) begin
            if (hold[i] > 0) begin
               hold[i]--;
            end else if (cnt[i] > 0) begin
               mask      = (8*N)'(8'hFF) << (8 * i);
               req_data  = (req_data & ~mask) | ((8*N)'(scr[i][hd[i]][7:0]) << (8 * i));
               req_last  = scr[i][hd[i]][8] ? (req_last | onehot(i)) : (req_last & ~onehot(i));
               req_valid |= onehot(i);
            end
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      drive();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic wait_start(input int mark);
      int k;
      k = 0;
      while (slog_n <= mark && k < 50) begin step(); k++; end
      chk("start_seen", 32'(slog_n > mark), 32'd1);
   endtask

   function automatic bit drained();
      bit e;
      e = 1;
      for (int i = 0; i < N; i++) if (cnt[i] != 0) e = 0;
      return e && (req_valid == '0) && !busy;
   endfunction

   task automatic wait_idle(input int max);
      int k;
      k = 0;
      while (!drained() && k < max) begin step(); k++; end
      chk("drain", 32'(drained()), 32'd1);
   endtask

   initial begin : main
      int mark, total, len;
      rst = 1'b1;
      req_valid = '0; req_last = '0; req_data = '0;
      for (int i = 0; i < N; i++) begin hd[i] = 0; cnt[i] = 0; hold[i] = 0; end
      #1 rst = 1'b0;

      // Reset with all requesters valid
      push(0, 8'h3C, 1); push(1, 8'hC1, 1); push(2, 8'hC2, 1); push(3, 8'hC3, 1);
      run(3);
      chk("rst_valid_all", 32'(req_valid), 32'hF);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_tx_start", 32'(tx_start), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      rst = 1'b1;
      step();
      chk("rel_tx_start", 32'(tx_start), 32'd1);
      chk("rel_grant", 32'(grant), 32'h1);
      chk("rel_tx_din", 32'(tx_din), 32'h3C);
      wait_idle(200);
      for (int k = 0; k < 4; k++) chk("rel_order", 32'(slog_gid[k]), 32'(k));
      chk("rel_din3", 32'(slog_din[3]), 32'hC3);

      // Single-byte packet from requester 2
      mark = slog_n;
      push(2, 8'hA5, 1);
      wait_start(mark);
      chk("sb_tx_start", 32'(tx_start), 32'd1);
      chk("sb_tx_din", 32'(tx_din), 32'hA5);
      chk("sb_ready", 32'(req_ready), 32'h4);
      chk("sb_grant", 32'(grant), 32'h4);
      step();
      chk("sb_ready_drop", 32'(req_ready), 32'h0);
      chk("sb_start_drop", 32'(tx_start), 32'h0);
      chk("sb_din_hold", 32'(tx_din), 32'hA5);
      wait_idle(200);
      chk("sb_grant_clr", 32'(grant), 32'h0);
      chk("sb_busy_clr", 32'(busy), 32'h0);
      // rr_ptr must now be 3
      mark = slog_n;
      push(0, 8'hB0, 1); push(2, 8'hB2, 1); push(3, 8'hB3, 1);
      wait_start(mark);
      chk("ptr3_grant", 32'(grant), 32'h8);
      wait_idle(200);
      chk("ptr3_o1", 32'(slog_gid[mark + 1]), 32'd0);
      chk("ptr3_o2", 32'(slog_gid[mark + 2]), 32'd2);

      // Packet lock: requester 0 three bytes while requester 1 waits
      mark = slog_n;
      push(0, 8'h11, 0); push(0, 8'h22, 0); push(0, 8'h33, 1); push(1, 8'h44, 1);
      wait_idle(300);
      chk("lock_b0", 32'(slog_din[mark]), 32'h11);
      chk("lock_b1", 32'(slog_din[mark + 1]), 32'h22);
      chk("lock_b2", 32'(slog_din[mark + 2]), 32'h33);
      chk("lock_b3", 32'(slog_din[mark + 3]), 32'h44);
      chk("lock_g2", 32'(slog_gid[mark + 2]), 32'd0);
      chk("lock_g3", 32'(slog_gid[mark + 3]), 32'd1);

      // Stall in NEXT: requester 3 pauses mid-packet, requester 0 waits
      mark = slog_n;
      push(3, 8'hD1, 0); push(0, 8'hE0, 1);
      wait_start(mark);
      run(15);
      force_tick = 1; step(); force_tick = 0;
      run(34);
      chk("stall_starts", 32'(slog_n - mark), 32'd1);
      chk("stall_grant", 32'(grant), 32'h8);
      chk("stall_busy", 32'(busy), 32'd1);
      push(3, 8'hD2, 1);
      wait_idle(200);
      chk("stall_d2", 32'(slog_din[mark + 1]), 32'hD2);
      chk("stall_g1", 32'(slog_gid[mark + 1]), 32'd3);
      chk("stall_next", 32'(slog_gid[mark + 2]), 32'd0);

      // Fairness: every requester has two single-byte packets; pointer starts at 1
      mark = slog_n;
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++) push(i, 8'(8'h60 + 16 * r + i), 1);
      wait_idle(400);
      for (int k = 0; k < 8; k++) chk("fair_order", 32'(slog_gid[mark + k]), 32'((1 + k) % 4));

      // Randomized traffic
      rand_on = 1; spur_en = 1;
      mark = slog_n; total = 0;
      for (int i = 0; i < N; i++)
         for (int p = 0; p < 12; p++) begin
            len = int'($urandom_range(1, 4));
            for (int b = 0; b < len; b++) push(i, 8'($urandom), b == len - 1);
            total += len;
         end
      wait_idle(20000);
      chk("rand_bytes", 32'(slog_n - mark), 32'(total));
      rand_on = 0; spur_en = 0;

`ifdef UART_ARB_TIMEOUT_EN
      // Watchdog: frame never completes
      uart_mute = 1;
      mark = slog_n;
      push(1, 8'h5A, 0);
      wait_start(mark);
      run(99);
      chk("to_before", 32'(timeout_err), 32'd0);
      chk("to_grant_before", 32'(grant), 32'h2);
      step();
      chk("to_flag", 32'(timeout_err), 32'd1);
      chk("to_grant", 32'(grant), 32'h0);
      chk("to_busy", 32'(busy), 32'd0);
      uart_mute = 0;
      mark = slog_n;
      push(2, 8'h6B, 1); push(0, 8'h60, 1);
      wait_idle(200);
      chk("to_ptr", 32'(slog_gid[mark]), 32'd2);
      chk("to_sticky", 32'(timeout_err), 32'd1);
      rst = 1'b0;
      step();
      chk("to_rst_clr", 32'(timeout_err), 32'd0);
      rst = 1'b1;
      run(2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
